// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: NUM_REQ streaming producers share one
// fifo_sync write port. One requester is granted at a time for a burst of
// up to BURST_LEN beats; writes are gated by the FIFO full flag.
//
// Handshake: a beat moves from requester i into the FIFO in any cycle where
// req_valid[i] and req_ready[i] are both high (that is also fifo_wr_en).
// req_ready[i] depends only on arbiter state and fifo_full, never on
// req_valid, so a producer may hold data stable until it sees ready.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int SIZE      = 32,
    parameter int BURST_LEN = 4,
    parameter int ATOMIC    = 0,
    localparam int SIZE_W   = $clog2(SIZE) + 1,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BEAT_W   = $clog2(BURST_LEN) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         fifo_data_wr,
    output logic                      fifo_wr_en,
    input  logic [SIZE_W-1:0]         fifo_data_count,
    input  logic                      fifo_full,
    output logic                      grant_active,
    output logic [ID_W-1:0]           grant_id,
    output logic                      burst_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [SIZE_W:0]   SIZE_X    = (SIZE_W + 1)'(SIZE);
    localparam logic [SIZE_W:0]   BURST_X   = (SIZE_W + 1)'(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    state_t              state;
    state_t              state_next;
    logic [ID_W-1:0]     grant_id_next;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BEAT_W-1:0]   beat_cnt_next;
    logic                grant_active_next;
    logic                burst_done_next;
    logic [ID_W-1:0]     winner;
    logic                winner_found;
    logic [ID_W-1:0]     cand;
    logic [SIZE_W:0]     free_space;
    logic                space_ok;

    // Free space is compared one bit wider than data_count so SIZE itself fits.
    assign free_space = SIZE_X - {1'b0, fifo_data_count};
    assign space_ok   = (ATOMIC == 0) || (free_space >= BURST_X);

    // Route the granted requester to the FIFO write port and raise its ready.
    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_data_wr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                req_ready[i] = (state == BURST) && !fifo_full;
                fifo_wr_en   = (state == BURST) && !fifo_full && req_valid[i];
                fifo_data_wr = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Cyclic search for the next valid requester, starting just past grant_id.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        cand         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(grant_id) + k) % NUM_REQ);
            if (!winner_found && req_valid[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats / stall / release in BURST.
    always_comb begin
        state_next        = state;
        grant_id_next     = grant_id;
        beat_cnt_next     = beat_cnt;
        grant_active_next = grant_active;
        burst_done_next   = 1'b0;
        case (state)
            IDLE: begin
                if (winner_found && space_ok) begin
                    state_next        = BURST;
                    grant_id_next     = winner;
                    beat_cnt_next     = '0;
                    grant_active_next = 1'b1;
                end
            end
            BURST: begin
                // A full FIFO freezes the grant; valid is not looked at then.
                if (!fifo_full) begin
                    if (fifo_wr_en && (beat_cnt != LAST_BEAT)) begin
                        beat_cnt_next = beat_cnt + 1'b1;
                    end else begin
                        // Last beat accepted, or the grantee went idle.
                        state_next        = IDLE;
                        grant_active_next = 1'b0;
                        burst_done_next   = 1'b1;
                    end
                end
            end
            default: begin
                state_next        = IDLE;
                grant_active_next = 1'b0;
            end
        endcase
    end

    // State and output registers; pointer resets to the last index so 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            grant_id     <= ID_W'(NUM_REQ - 1);
            beat_cnt     <= '0;
            grant_active <= 1'b0;
            burst_done   <= 1'b0;
        end else begin
            state        <= state_next;
            grant_id     <= grant_id_next;
            beat_cnt     <= beat_cnt_next;
            grant_active <= grant_active_next;
            burst_done   <= burst_done_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: one non-atomic instance feeding a
// FIFO model, plus an ATOMIC=1 instance driven with a hand-set data count.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_valid_a;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  req_ready_a;
    logic [7:0]  fifo_data_wr;
    logic [7:0]  fifo_data_wr_a;
    logic        fifo_wr_en;
    logic        fifo_wr_en_a;
    logic [5:0]  fifo_data_count;
    logic [5:0]  count_a;
    logic        fifo_full;
    logic        full_a;
    logic        ga;
    logic        ga_a;
    logic [1:0]  gid;
    logic [1:0]  gid_a;
    logic        bd;
    logic        bd_a;

    logic        fifo_rd;
    logic        preset_en;
    logic [5:0]  preset_val;

    int vectors = 0;
    int errors  = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .SIZE(32), .BURST_LEN(4), .ATOMIC(0)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_data_wr(fifo_data_wr), .fifo_wr_en(fifo_wr_en),
        .fifo_data_count(fifo_data_count), .fifo_full(fifo_full),
        .grant_active(ga), .grant_id(gid), .burst_done(bd)
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .SIZE(32), .BURST_LEN(4), .ATOMIC(1)) dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_data(req_data),
        .req_ready(req_ready_a), .fifo_data_wr(fifo_data_wr_a), .fifo_wr_en(fifo_wr_en_a),
        .fifo_data_count(count_a), .fifo_full(full_a),
        .grant_active(ga_a), .grant_id(gid_a), .burst_done(bd_a)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // 32-deep FIFO model: counts occupancy and logs every written word.
    assign fifo_full = (fifo_data_count == 6'd32);
    always @(posedge clk) begin
        if (reset) begin
            fifo_data_count <= '0;
            got_q.delete();
        end else if (preset_en) begin
            fifo_data_count <= preset_val;
        end else begin
            if (fifo_wr_en && fifo_full) begin
                errors++;
                $display("FAIL overflow: wr_en=1 while full, count=%0d", fifo_data_count);
            end
            if (fifo_wr_en && !fifo_full) got_q.push_back(fifo_data_wr);
            fifo_data_count <= fifo_data_count
                               + 6'((fifo_wr_en && !fifo_full) ? 1 : 0)
                               - 6'((fifo_rd && fifo_data_count != 0) ? 1 : 0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; req_valid = '0; req_valid_a = '0; fifo_rd = 1'b0;
        preset_en = 1'b0; preset_val = '0; count_a = '0; full_a = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 4'hF; req_valid_a = 4'hF; req_data = 32'h03020100;
        fifo_rd = 1'b0; preset_en = 1'b0; preset_val = '0; count_a = '0; full_a = 1'b0;
        cyc();
        cyc();
        settle();
        vectors++; if (ga !== 1'b0) begin errors++; $display("FAIL reset_ga got %0b want 0", ga); end
        vectors++; if (bd !== 1'b0) begin errors++; $display("FAIL reset_bd got %0b want 0", bd); end
        vectors++; if (gid !== 2'd3) begin errors++; $display("FAIL reset_gid got %0d want 3", gid); end
        vectors++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr got %0b want 0", fifo_wr_en); end
        vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        vectors++; if (ga_a !== 1'b0) begin errors++; $display("FAIL reset_ga_a got %0b want 0", ga_a); end
        vectors++; if (gid_a !== 2'd3) begin errors++; $display("FAIL reset_gid_a got %0d want 3", gid_a); end
        req_valid = '0; req_valid_a = '0;
    endtask

    task automatic test_single_stream();
        int idx = 0;
        logic [11:0] wr_tr, ga_tr, bd_tr;
        apply_reset();
        req_data = '0;
        for (int c = 0; c < 12; c++) begin
            req_valid = (idx < 8) ? 4'b0001 : 4'b0000;
            req_data[7:0] = 8'(8'h10 + idx);
            settle();
            wr_tr[c] = fifo_wr_en; ga_tr[c] = ga; bd_tr[c] = bd;
            if (c == 1 || c == 6) begin
                vectors++; if (gid !== 2'd0) begin errors++; $display("FAIL single_gid c%0d got %0d want 0", c, gid); end
            end
            if (fifo_wr_en) idx++;
            cyc();
        end
        vectors++; if (wr_tr !== 12'b0011_1101_1110) begin errors++; $display("FAIL single_wr_trace got %b want 001111011110", wr_tr); end
        vectors++; if (ga_tr !== 12'b0011_1101_1110) begin errors++; $display("FAIL single_ga_trace got %b want 001111011110", ga_tr); end
        vectors++; if (bd_tr !== 12'b0100_0010_0000) begin errors++; $display("FAIL single_bd_trace got %b want 010000100000", bd_tr); end
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h10 + i));
        vectors++; if (got_q.size() != 8) begin errors++; $display("FAIL single_count got %0d want 8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
        req_valid = '0;
    endtask

    task automatic test_back_to_back();
        logic exp_wr;
        logic [1:0] exp_gid;
        apply_reset();
        req_data = 32'hA3A2A1A0;
        req_valid = 4'hF;
        for (int c = 0; c < 25; c++) begin
            settle();
            exp_wr = ((c % 5) != 0);
            vectors++; if (fifo_wr_en !== exp_wr) begin errors++; $display("FAIL rr_wr c%0d got %0b want %0b", c, fifo_wr_en, exp_wr); end
            if ((c % 5) == 1) begin
                exp_gid = 2'((c / 5) % 4);
                vectors++; if (gid !== exp_gid) begin errors++; $display("FAIL rr_gid c%0d got %0d want %0d", c, gid, exp_gid); end
            end
            cyc();
        end
        req_valid = '0;
        exp_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back(8'(8'hA0 + (i / 4) % 4));
        vectors++; if (got_q.size() != 20) begin errors++; $display("FAIL rr_count got %0d want 20", got_q.size()); end
        for (int i = 0; i < 20 && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_full_stall();
        apply_reset();
        req_data = 32'h00C20000;
        preset_en = 1'b1; preset_val = 6'd30;
        cyc();
        preset_en = 1'b0; req_valid = 4'b0100;
        settle();
        vectors++; if (ga !== 1'b0) begin errors++; $display("FAIL stall_idle_ga got %0b want 0", ga); end
        cyc();
        settle();
        vectors++; if (gid !== 2'd2) begin errors++; $display("FAIL stall_gid got %0d want 2", gid); end
        vectors++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL stall_beat1 got %0b want 1", fifo_wr_en); end
        vectors++; if (fifo_data_wr !== 8'hC2) begin errors++; $display("FAIL stall_data got %h want c2", fifo_data_wr); end
        cyc();
        settle();
        vectors++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL stall_beat2 got %0b want 1", fifo_wr_en); end
        cyc();
        settle();
        vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready got %b want 0000", req_ready); end
        vectors++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL stall_wr got %0b want 0", fifo_wr_en); end
        vectors++; if (ga !== 1'b1) begin errors++; $display("FAIL stall_ga got %0b want 1", ga); end
        vectors++; if (gid !== 2'd2) begin errors++; $display("FAIL stall_gid_held got %0d want 2", gid); end
        cyc();
        settle();
        vectors++; if (ga !== 1'b1) begin errors++; $display("FAIL stall_ga2 got %0b want 1", ga); end
        fifo_rd = 1'b1;
        cyc();
        fifo_rd = 1'b0;
        settle();
        vectors++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL resume_ready got %b want 0100", req_ready); end
        vectors++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL resume_beat3 got %0b want 1", fifo_wr_en); end
        cyc();
        settle();
        vectors++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL restall_wr got %0b want 0", fifo_wr_en); end
        vectors++; if (bd !== 1'b0) begin errors++; $display("FAIL restall_bd got %0b want 0", bd); end
        fifo_rd = 1'b1;
        cyc();
        fifo_rd = 1'b0;
        settle();
        vectors++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL resume_beat4 got %0b want 1", fifo_wr_en); end
        cyc();
        req_valid = '0;
        settle();
        vectors++; if (bd !== 1'b1) begin errors++; $display("FAIL stall_end_bd got %0b want 1", bd); end
        vectors++; if (ga !== 1'b0) begin errors++; $display("FAIL stall_end_ga got %0b want 0", ga); end
        vectors++; if (got_q.size() != 4) begin errors++; $display("FAIL stall_count got %0d want 4", got_q.size()); end
    endtask

    task automatic test_early_release();
        apply_reset();
        req_data = 32'hD3D2D1D0;
        req_valid = 4'b0010;
        settle();
        vectors++; if (ga !== 1'b0) begin errors++; $display("FAIL early_idle_ga got %0b want 0", ga); end
        cyc();
        req_valid = 4'b0110;
        settle();
        vectors++; if (gid !== 2'd1) begin errors++; $display("FAIL early_gid got %0d want 1", gid); end
        vectors++; if (fifo_data_wr !== 8'hD1) begin errors++; $display("FAIL early_data got %h want d1", fifo_data_wr); end
        cyc();
        settle();
        vectors++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL early_beat2 got %0b want 1", fifo_wr_en); end
        cyc();
        req_valid = 4'b0100;
        settle();
        vectors++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL early_drop_wr got %0b want 0", fifo_wr_en); end
        vectors++; if (bd !== 1'b0) begin errors++; $display("FAIL early_drop_bd got %0b want 0", bd); end
        cyc();
        settle();
        vectors++; if (bd !== 1'b1) begin errors++; $display("FAIL early_bd got %0b want 1", bd); end
        vectors++; if (ga !== 1'b0) begin errors++; $display("FAIL early_ga got %0b want 0", ga); end
        vectors++; if (gid !== 2'd1) begin errors++; $display("FAIL early_ptr got %0d want 1", gid); end
        cyc();
        settle();
        vectors++; if (gid !== 2'd2) begin errors++; $display("FAIL early_next_gid got %0d want 2", gid); end
        vectors++; if (bd !== 1'b0) begin errors++; $display("FAIL early_bd_clear got %0b want 0", bd); end
        vectors++; if (fifo_data_wr !== 8'hD2) begin errors++; $display("FAIL early_next_data got %h want d2", fifo_data_wr); end
        req_valid = '0;
    endtask

    task automatic test_atomic();
        apply_reset();
        count_a = 6'd29;
        req_valid_a = 4'hF;
        for (int c = 0; c < 3; c++) begin
            settle();
            vectors++; if (ga_a !== 1'b0) begin errors++; $display("FAIL atomic_hold c%0d got %0b want 0", c, ga_a); end
            cyc();
        end
        count_a = 6'd28;
        settle();
        vectors++; if (ga_a !== 1'b0) begin errors++; $display("FAIL atomic_pre got %0b want 0", ga_a); end
        cyc();
        settle();
        vectors++; if (ga_a !== 1'b1) begin errors++; $display("FAIL atomic_grant got %0b want 1", ga_a); end
        vectors++; if (gid_a !== 2'd0) begin errors++; $display("FAIL atomic_gid got %0d want 0", gid_a); end
        vectors++; if (req_ready_a !== 4'b0001) begin errors++; $display("FAIL atomic_ready got %b want 0001", req_ready_a); end
        req_valid_a = '0;
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        req_data = 32'hD3D2D1D0;
        req_valid = 4'b0110;
        cyc();
        settle();
        vectors++; if (gid !== 2'd1) begin errors++; $display("FAIL midrst_gid got %0d want 1", gid); end
        cyc();
        settle();
        vectors++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL midrst_beat2 got %0b want 1", fifo_wr_en); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        settle();
        vectors++; if (ga !== 1'b0) begin errors++; $display("FAIL midrst_ga got %0b want 0", ga); end
        vectors++; if (bd !== 1'b0) begin errors++; $display("FAIL midrst_bd got %0b want 0", bd); end
        vectors++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL midrst_wr got %0b want 0", fifo_wr_en); end
        vectors++; if (gid !== 2'd3) begin errors++; $display("FAIL midrst_ptr got %0d want 3", gid); end
        cyc();
        settle();
        vectors++; if (ga !== 1'b1) begin errors++; $display("FAIL midrst_regrant got %0b want 1", ga); end
        vectors++; if (gid !== 2'd1) begin errors++; $display("FAIL midrst_regrant_gid got %0d want 1", gid); end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_back_to_back();
        test_full_stall();
        test_early_release();
        test_atomic();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
